// File: rtl/biquad_coeff_loader.sv
// biquad_coeff_loader: host-side staging store and serial loader for the
// incremental biquad coefficient port (coeff_dat / coeff_wr / coeff_update).
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   wr_en_i         staging write strobe (accepted only while idle)
//   wr_addr_i       chain position, 0 = first DSP next to the coeff port
//   wr_data_i       coefficient value
//   commit_i        request to shift the staged set into the chain
//   busy_o          load sequence in progress
//   done_o          one-cycle pulse after the update pulse
//   wr_err_o        sticky rejected-write flag, cleared by an accepted commit
//   coeff_dat_o     serial coefficient data to the filter
//   coeff_wr_o      shift strobe to the filter
//   coeff_update_o  B1 -> B2 copy pulse to the filter
module biquad_coeff_loader #(
    parameter int NCOEFF     = 12,
    parameter int COEFF_BITS = 18,
    parameter int GAP_CYCLES = 2,
    parameter int ADDR_BITS  = $clog2(NCOEFF)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en_i,
    input  logic [ADDR_BITS-1:0]  wr_addr_i,
    input  logic [COEFF_BITS-1:0] wr_data_i,
    input  logic                  commit_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  wr_err_o,
    output logic [COEFF_BITS-1:0] coeff_dat_o,
    output logic                  coeff_wr_o,
    output logic                  coeff_update_o
);

    localparam int LP_IW = $clog2(NCOEFF);
    localparam int LP_GW = $clog2(GAP_CYCLES) + 1;

    localparam logic [LP_IW-1:0] LP_CNT_TOP = LP_IW'(NCOEFF - 1);
    localparam logic [LP_GW-1:0] LP_GAP_TOP = LP_GW'(GAP_CYCLES - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
    localparam logic [1:0] ST_GAP    = 2'd2;
    localparam logic [1:0] ST_UPDATE = 2'd3;

    // Reset synchroniser: assertion is immediate, release is aligned to clk.
    logic r_rst_meta;
    logic r_rst_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rst_meta <= 1'b1;
            r_rst_sync <= 1'b1;
        end else begin
            r_rst_meta <= 1'b0;
            r_rst_sync <= r_rst_meta;
        end
    end

    logic [1:0]            r_state;
    logic [LP_IW-1:0]      r_cnt;
    logic [LP_GW-1:0]      r_gcnt;
    logic                  r_pend;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_err;
    logic [COEFF_BITS-1:0] r_dat;
    logic                  r_wr;
    logic                  r_upd;

    logic [COEFF_BITS-1:0] r_mem [NCOEFF];

    logic                  w_addr_ok;
    logic                  w_wr_acc;
    logic                  w_wr_rej;
    logic                  w_pend_nx;
    logic [LP_IW-1:0]      w_idx;
    logic [COEFF_BITS-1:0] w_rd;

    assign w_addr_ok = (32'(wr_addr_i) < 32'(NCOEFF));
    assign w_idx     = wr_addr_i[LP_IW-1:0];

    // r_busy also covers the idle cycle that precedes a queued reload,
    // so staging is frozen for the whole back-to-back sequence.
    assign w_wr_acc  = wr_en_i & ~r_busy & w_addr_ok & ~r_rst_sync;
    assign w_wr_rej  = wr_en_i & (r_busy | ~w_addr_ok);
    assign w_pend_nx = r_pend | commit_i;
    assign w_rd      = r_mem[r_cnt];

    // Staging store is deliberately not reset: a reset mid-load must not
    // lose the host's staged set.
    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[w_idx] <= wr_data_i;
        end
    end

    always_ff @(posedge clk or posedge r_rst_sync) begin
        if (r_rst_sync) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_gcnt  <= '0;
            r_pend  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_dat   <= '0;
            r_wr    <= 1'b0;
            r_upd   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (commit_i | r_pend) begin
                        r_state <= ST_SHIFT;
                        r_cnt   <= LP_CNT_TOP;
                        r_wr    <= 1'b1;
                        r_busy  <= 1'b1;
                        r_pend  <= 1'b0;
                        r_err   <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    // The filter delays the strobe by one cycle, so the
                    // data register trails coeff_wr_o by one cycle.
                    r_dat <= w_rd;
                    if (r_cnt == '0) begin
                        r_state <= ST_GAP;
                        r_wr    <= 1'b0;
                        r_gcnt  <= LP_GAP_TOP;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                    if (commit_i) begin
                        r_pend <= 1'b1;
                    end
                end
                ST_GAP: begin
                    if (r_gcnt == '0) begin
                        r_state <= ST_UPDATE;
                        r_upd   <= 1'b1;
                    end else begin
                        r_gcnt <= r_gcnt - 1'b1;
                    end
                    if (commit_i) begin
                        r_pend <= 1'b1;
                    end
                end
                ST_UPDATE: begin
                    // A queued commit keeps busy high through the done
                    // cycle and restarts the shift from IDLE next cycle.
                    r_upd   <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= ST_IDLE;
                    r_busy  <= w_pend_nx;
                    r_pend  <= w_pend_nx;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
            // A rejected write in the commit cycle still leaves the flag set.
            if (w_wr_rej) begin
                r_err <= 1'b1;
            end
        end
    end

    assign busy_o         = r_busy;
    assign done_o         = r_done;
    assign wr_err_o       = r_err;
    assign coeff_dat_o    = r_dat;
    assign coeff_wr_o     = r_wr;
    assign coeff_update_o = r_upd;

endmodule

// File: tb/tb_biquad_coeff_loader.sv
// tb_biquad_coeff_loader: directed bench for biquad_coeff_loader with
// NCOEFF=4, GAP_CYCLES=2 and a behavioural B1/B2 chain model.
module tb_biquad_coeff_loader;

    localparam int N  = 4;
    localparam int W  = 18;
    localparam int G  = 2;
    localparam int AB = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          wr_en_i = 1'b0;
    logic [AB-1:0] wr_addr_i = '0;
    logic [W-1:0]  wr_data_i = '0;
    logic          commit_i = 1'b0;
    logic          busy_o;
    logic          done_o;
    logic          wr_err_o;
    logic [W-1:0]  coeff_dat_o;
    logic          coeff_wr_o;
    logic          coeff_update_o;

    biquad_coeff_loader #(
        .NCOEFF    (N),
        .COEFF_BITS(W),
        .GAP_CYCLES(G),
        .ADDR_BITS (AB)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .wr_en_i       (wr_en_i),
        .wr_addr_i     (wr_addr_i),
        .wr_data_i     (wr_data_i),
        .commit_i      (commit_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .wr_err_o      (wr_err_o),
        .coeff_dat_o   (coeff_dat_o),
        .coeff_wr_o    (coeff_wr_o),
        .coeff_update_o(coeff_update_o)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_tot  = 0;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", nm, act, exp);
    endtask

    // Filter model: strobe registered once, then B1 shifts; update copies.
    logic         m_wr_d = 1'b0;
    logic [W-1:0] b1 [N];
    logic [W-1:0] b2 [N];
    int           n_upd = 0;
    bit           both = 1'b0;

    always @(posedge clk) begin
        m_wr_d <= coeff_wr_o;
        if (m_wr_d) begin
            b1[0] <= coeff_dat_o;
            for (int i = 1; i < N; i++) b1[i] <= b1[i-1];
        end
        if (coeff_update_o) begin
            for (int i = 0; i < N; i++) b2[i] <= b1[i];
            n_upd++;
        end
    end

    always @(negedge clk) begin
        if (coeff_wr_o && coeff_update_o) both = 1'b1;
    end

    function automatic logic [N-1:0][W-1:0] b2p();
        logic [N-1:0][W-1:0] r;
        for (int i = 0; i < N; i++) r[i] = b2[i];
        return r;
    endfunction

    typedef struct {
        logic          we;
        logic [AB-1:0] a;
        logic [W-1:0]  d;
        logic          cm;
        logic          ewr;
        logic [W-1:0]  edat;
        logic          eupd;
        logic          ebusy;
        logic          edone;
        logic          eerr;
    } vec_t;

    vec_t tv[$];

    task automatic add(input logic we, input int a, input int d,
                       input logic cm, input logic ewr, input int edat,
                       input logic eupd, input logic ebusy,
                       input logic edone, input logic eerr);
        vec_t v;
        v.we = we; v.a = AB'(a); v.d = W'(d); v.cm = cm;
        v.ewr = ewr; v.edat = W'(edat); v.eupd = eupd;
        v.ebusy = ebusy; v.edone = edone; v.eerr = eerr;
        tv.push_back(v);
    endtask

    task automatic do_write(input int a, input int d);
        wr_en_i = 1'b1; wr_addr_i = AB'(a); wr_data_i = W'(d);
        @(posedge clk); #1;
        wr_en_i = 1'b0;
    endtask

    // Commit, then check strobe, data order, update timing and B2 stability.
    task automatic run_seq(input logic [N-1:0][W-1:0] m, input string tag);
        logic [N-1:0][W-1:0] snap;
        commit_i = 1'b1;
        @(posedge clk); #1;
        commit_i = 1'b0;
        snap = b2p();
        chk({tag, "_start"}, {coeff_wr_o, busy_o, wr_err_o}, 3'b110);
        for (int k = 0; k < N; k++) begin
            @(posedge clk); #1;
            chk($sformatf("%s_dat%0d", tag, k), coeff_dat_o, m[N-1-k]);
        end
        chk({tag, "_wr_off"}, {coeff_wr_o, coeff_update_o, busy_o}, 3'b001);
        repeat (G) @(posedge clk);
        #1;
        chk({tag, "_upd"}, {coeff_update_o, busy_o, done_o}, 3'b110);
        chk({tag, "_b2_hold"}, b2p(), snap);
        @(posedge clk); #1;
        chk({tag, "_done"}, {done_o, busy_o, coeff_update_o}, 3'b100);
        chk({tag, "_b2_new"}, b2p(), m);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1);
    end

    initial begin
        logic [N-1:0][W-1:0] m1;
        logic [N-1:0][W-1:0] m2;
        int snap_upd;

        m1[0] = 18'h11;  m1[1] = 18'h22;  m1[2] = 18'h33;  m1[3] = 18'h44;
        m2[0] = 18'h101; m2[1] = 18'h102; m2[2] = 18'h103; m2[3] = 18'h104;

        //  we a  d        cm  wr dat   upd bsy dn err
        add(1, 0, 'h11,    0,  0, 0,    0,  0,  0, 0);
        add(1, 1, 'h22,    0,  0, 0,    0,  0,  0, 0);
        add(1, 2, 'h33,    0,  0, 0,    0,  0,  0, 0);
        add(1, 3, 'h44,    1,  1, 0,    0,  1,  0, 0);
        add(0, 0, 0,       0,  1, 'h44, 0,  1,  0, 0);
        add(0, 0, 0,       0,  1, 'h33, 0,  1,  0, 0);
        add(1, 1, 'h3FFFF, 0,  1, 'h22, 0,  1,  0, 1);
        add(0, 0, 0,       0,  0, 'h11, 0,  1,  0, 1);
        add(0, 0, 0,       0,  0, 'h11, 0,  1,  0, 1);
        add(0, 0, 0,       0,  0, 'h11, 1,  1,  0, 1);
        add(0, 0, 0,       0,  0, 'h11, 0,  0,  1, 1);
        add(0, 0, 0,       0,  0, 'h11, 0,  0,  0, 1);
        add(0, 0, 0,       1,  1, 'h11, 0,  1,  0, 0);
        add(0, 0, 0,       0,  1, 'h44, 0,  1,  0, 0);
        add(0, 0, 0,       1,  1, 'h33, 0,  1,  0, 0);
        add(0, 0, 0,       1,  1, 'h22, 0,  1,  0, 0);
        add(0, 0, 0,       0,  0, 'h11, 0,  1,  0, 0);
        add(0, 0, 0,       0,  0, 'h11, 0,  1,  0, 0);
        add(0, 0, 0,       0,  0, 'h11, 1,  1,  0, 0);
        add(0, 0, 0,       0,  0, 'h11, 0,  1,  1, 0);
        add(0, 0, 0,       0,  1, 'h11, 0,  1,  0, 0);
        add(0, 0, 0,       0,  1, 'h44, 0,  1,  0, 0);
        add(0, 0, 0,       0,  1, 'h33, 0,  1,  0, 0);
        add(0, 0, 0,       0,  1, 'h22, 0,  1,  0, 0);
        add(0, 0, 0,       0,  0, 'h11, 0,  1,  0, 0);
        add(0, 0, 0,       0,  0, 'h11, 0,  1,  0, 0);
        add(0, 0, 0,       0,  0, 'h11, 1,  1,  0, 0);
        add(0, 0, 0,       0,  0, 'h11, 0,  0,  1, 0);
        add(0, 0, 0,       0,  0, 'h11, 0,  0,  0, 0);

        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outs",
            {coeff_wr_o, coeff_dat_o, coeff_update_o, busy_o, done_o, wr_err_o},
            '0);
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        foreach (tv[i]) begin
            wr_en_i = tv[i].we; wr_addr_i = tv[i].a;
            wr_data_i = tv[i].d; commit_i = tv[i].cm;
            @(posedge clk); #1;
            chk($sformatf("vec%0d", i),
                {coeff_wr_o, coeff_dat_o, coeff_update_o, busy_o, done_o, wr_err_o},
                {tv[i].ewr, tv[i].edat, tv[i].eupd, tv[i].ebusy,
                 tv[i].edone, tv[i].eerr});
        end
        wr_en_i = 1'b0; commit_i = 1'b0;
        chk("table_b2", b2p(), m1);

        // New set: checks B2 stays put until the update pulse.
        for (int i = 0; i < N; i++) do_write(i, int'(m2[i]));
        run_seq(m2, "seqA");

        // Reset in the middle of the shift burst.
        commit_i = 1'b1;
        @(posedge clk); #1;
        commit_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("mid_shift_wr", {coeff_wr_o, busy_o}, 2'b11);
        snap_upd = n_upd;
        rst = 1'b1;
        #1;
        chk("mid_rst_outs",
            {coeff_wr_o, coeff_dat_o, coeff_update_o, busy_o, done_o, wr_err_o},
            '0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("rst_no_upd", n_upd, snap_upd);
        chk("rst_b2_kept", b2p(), m2);
        run_seq(m2, "seqB");

        // Out-of-range addresses in IDLE must not alias onto real entries.
        do_write(5, 'h3FFFF);
        chk("addr5_err", wr_err_o, 1'b1);
        do_write(4, 'h3FFFE);
        chk("addr4_err", {wr_err_o, busy_o}, 2'b10);
        run_seq(m2, "seqC");

        chk("wr_upd_excl", both, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/biquad_coeff_loader.md
Name: biquad_coeff_loader

Overview:
Host-side writer for the serial coefficient port (coeff_dat/coeff_wr/coeff_update) of the incremental biquad DSP chain. Host writes coefficients at random into a staging store. On commit, an FSM shifts all of them into the DSP B1 cascade chain in chain order, then pulses update so every DSP copies B1 to B2 in the same cycle. Sits between the register bus and one biquad8 filter instance.

Parameters:
NCOEFF, 12, number of B registers in the cascade chain (2 per incremental stage; NSAMP=8 gives 12)
COEFF_BITS, 18, coefficient word width (DSP B port)
GAP_CYCLES, 2, idle cycles between the last shift strobe and the update pulse (≥1)
ADDR_BITS, $clog2(NCOEFF), staging address width

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
wr_en_i  in  1  staging write strobe
wr_addr_i  in  ADDR_BITS  chain position (0 = first DSP, nearest coeff port)
wr_data_i  in  COEFF_BITS  coefficient value
commit_i  in  1  single-cycle request to load the staged set
busy_o  out  1  load sequence in progress
done_o  out  1  one-cycle pulse when update has been issued
wr_err_o  out  1  sticky: staging write rejected; cleared by an accepted commit
coeff_dat_o  out  COEFF_BITS  to filter coeff_dat_i
coeff_wr_o  out  1  to filter coeff_wr_i (shift strobe)
coeff_update_o  out  1  to filter coeff_update_i

Behaviour:
- Reset (async assert, sync deassert internally): all outputs 0, FSM IDLE, pending flag 0. Staging store is not cleared; contents persist across reset and are undefined at power-up.
- Staging: wr_en_i in IDLE writes mem[wr_addr_i] in the next cycle. If wr_en_i is high while busy_o=1, or wr_addr_i ≥ NCOEFF, the write is dropped and wr_err_o is set.
- FSM states: IDLE, SHIFT, GAP, UPDATE.
- IDLE: commit_i=1 at cycle T moves to SHIFT at T+1, clears wr_err_o and sets busy_o=1. If wr_en_i and commit_i are high together, the write completes first, so the committed set includes it.
- SHIFT: coeff_wr_o=1 for exactly NCOEFF cycles, T+1..T+NCOEFF. The filter registers the strobe one cycle before it enables B1, so data lags the strobe by one cycle: coeff_dat_o = mem[NCOEFF-1-k] during cycle T+2+k, for k=0..NCOEFF-1. The first word shifted ends farthest down the chain. A down-counter runs from NCOEFF-1 to 0.
- GAP: coeff_wr_o=0 for GAP_CYCLES cycles. coeff_dat_o holds the last word (mem[0]) through GAP and afterwards until the next load.
- UPDATE: coeff_update_o=1 for one cycle, T+NCOEFF+GAP_CYCLES+1. Next cycle: done_o=1, busy_o=0, state IDLE.
- busy_o is high from T+1 through the UPDATE cycle inclusive.
- Commit while busy: sets the pending flag; multiple requests merge into one. When done_o fires with pending set, the FSM goes directly to SHIFT the next cycle (pending cleared) and busy_o stays 1 in that cycle.
- Reset mid-sequence: immediate return to IDLE with all outputs 0. No update pulse is issued, so the filter's B2 (active) coefficients are untouched; only B1 is partially shifted. The host must recommit.
- coeff_wr_o and coeff_update_o are never high in the same cycle.
- All outputs are registered.
- Total sequence length: NCOEFF+GAP_CYCLES+1 cycles from commit to update.

Test Plan:
- NCOEFF=4, GAP=2: write mem = {0x00011, 0x00022, 0x00033, 0x00044} to addresses 0..3, commit at T -> coeff_wr_o high T+1..T+4; coeff_dat_o = 0x00044, 0x00033, 0x00022, 0x00011 at T+2..T+5; coeff_update_o at T+7; done_o at T+8.
- Same setup with a bit-accurate model of the DSP B1/B2 chain attached -> after update, B2 at position i equals mem[i] for all i, and B2 does not change before T+7.
- wr_en_i at T+3 during load, addr 1, data 0x3FFFF -> write dropped, mem[1] unchanged, wr_err_o=1; next commit clears wr_err_o.
- commit_i pulsed at T and again at T+2 and T+3 -> exactly two full sequences back-to-back; second coeff_wr_o burst starts the cycle after the first done_o.
- rst asserted at T+3 mid-shift -> all outputs 0 that cycle, no coeff_update_o; a recommit produces a full correct sequence using retained mem.
- wr_en_i with wr_addr_i=5 (NCOEFF=4) in IDLE -> wr_err_o=1, no staging entry modified.
